// File: rtl/rk4_result_reader.sv
// Captures the (X, Y) trajectory of one RK4 run into a buffer and replays it over valid/ready.
// Optional capture decimation is enabled by defining RK4_READER_DECIM_EN.
module rk4_result_reader #(
    parameter int N     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DECIM = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          wr_valid,
    input  logic [N-1:0]  x_in,
    input  logic [N-1:0]  y_in,
    input  logic          iter_done,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [N-1:0]  rd_x,
    output logic [N-1:0]  rd_y,
    output logic          rd_last,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          overflow,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t          state_reg, state_next;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            overflow_reg, done_reg, busy_reg;
    logic            rd_valid_reg, rd_last_reg;
    logic [N-1:0]    rd_x_reg, rd_y_reg;
    logic [2*N-1:0]  mem [DEPTH];
    logic [2*N-1:0]  rd_word;

    logic keep, full;
    logic wr_en, drop, load, xfer, xfer_last, done_next;

    assign full    = (count_reg == DEPTH_C);
    assign rd_word = mem[rd_ptr_reg];

`ifdef RK4_READER_DECIM_EN
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    logic [DW-1:0] decim_cnt_reg;

    // Only the first of every DECIM results is a storage candidate.
    assign keep = wr_valid && (decim_cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            decim_cnt_reg <= '0;
        else if (start)
            decim_cnt_reg <= '0;
        else if (state_reg == CAPTURE && wr_valid)
            decim_cnt_reg <= (decim_cnt_reg == DW'(DECIM - 1)) ? '0 : decim_cnt_reg + DW'(1);
    end
`else
    logic unused_decim;
    assign unused_decim = (DECIM >= 1);
    assign keep = wr_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CAPTURE;
            CAPTURE: begin
                if (start)
                    state_next = CAPTURE;
                else if (iter_done)
                    state_next = (count_reg != '0 || wr_en) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (start)
                    state_next = CAPTURE;
                else if (xfer_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_en     = 1'b0;
        drop      = 1'b0;
        load      = 1'b0;
        xfer      = 1'b0;
        xfer_last = 1'b0;
        done_next = 1'b0;
        case (state_reg)
            CAPTURE: if (!start) begin
                wr_en     = keep && !full;
                drop      = keep && full;
                done_next = iter_done && (count_reg == '0) && !wr_en;
            end
            DRAIN: if (!start) begin
                xfer      = rd_valid_reg && rd_ready;
                xfer_last = xfer && rd_last_reg;
                // Refill the output stage when it is empty or its word is being taken.
                load      = !rd_valid_reg || (xfer && !rd_last_reg);
                done_next = xfer_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= {x_in, y_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
            rd_x_reg     <= '0;
            rd_y_reg     <= '0;
        end else begin
            busy_reg <= (state_next != IDLE);
            done_reg <= done_next;
            if (start) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
                overflow_reg <= 1'b0;
                rd_valid_reg <= 1'b0;
                rd_last_reg  <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    count_reg  <= count_reg + (AW+1)'(1);
                end
                if (drop)
                    overflow_reg <= 1'b1;
                if (load) begin
                    rd_x_reg     <= rd_word[2*N-1:N];
                    rd_y_reg     <= rd_word[N-1:0];
                    rd_last_reg  <= ({1'b0, rd_ptr_reg} == count_reg - (AW+1)'(1));
                    rd_valid_reg <= 1'b1;
                    rd_ptr_reg   <= rd_ptr_reg + AW'(1);
                end else if (xfer_last) begin
                    rd_valid_reg <= 1'b0;
                    rd_last_reg  <= 1'b0;
                end
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_x     = rd_x_reg;
    assign rd_y     = rd_y_reg;
    assign rd_last  = rd_last_reg;
    assign count    = count_reg;
    assign busy     = busy_reg;
    assign overflow = overflow_reg;
    assign done     = done_reg;

endmodule
